// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the instruction-fetch slice: FSM encodings,
// default reset PC, ROM/instruction widths and the fetch-buffer entry type.
package if_fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ROM_AW = 6;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM encodings; 2'd3 is unused and never reached.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // One buffered fetch: the PC it was fetched from and the ROM word.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit bus: the instruction-ROM port and the decode handshake.
//
// Decode handshake: id_valid_o/id_pc_o/id_inst_o are driven by the fetch unit;
// an instruction transfers on a rising edge where id_valid_o && id_ready_i.
// While id_valid_o is high and id_ready_i is low, id_pc_o/id_inst_o hold.
// id_valid_o never depends on id_ready_i; id_ready_i may depend on id_valid_o.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic              rom_ce_o;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;

  logic              id_valid_o;
  logic              id_ready_i;
  logic [PC_W-1:0]   id_pc_o;
  logic [INST_W-1:0] id_inst_o;

  // Fetch-unit side.
  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_inst_i, id_ready_i
  );

  // ROM/decode side.
  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_inst_i, id_ready_i
  );

endinterface

// File: rtl/if_fetch_buf.sv
// Two-entry {pc, inst} FIFO between the ROM and decode. Flush wins over any
// same-cycle push or pop. Data storage is intentionally not reset.
module fetch_buf
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [1:0] LP_FULL = 2'(DEPTH);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/ERR control FSM and the
// redirect/stall handling, feeding a two-entry buffer towards decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_flag_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic            fetch_err_o,
  output logic [1:0]      dbg_state_o,
  output logic [1:0]      dbg_count_o,
  if_fetch_if.master      bus
);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;

  logic         w_run;
  logic         w_branch;
  logic         w_redirect;
  logic         w_misalign;
  logic         w_fetch;
  logic         w_valid;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  // Branch requests only matter in RUN; a misaligned target is fatal.
  assign w_run      = (r_state == ST_RUN);
  assign w_branch   = w_run && branch_flag_i;
  assign w_redirect = w_branch && (branch_target_i[1:0] == 2'b00);
  assign w_misalign = w_branch && (branch_target_i[1:0] != 2'b00);

  // Any branch request (taken or not) blocks the fetch, and so does stall.
  assign w_fetch = w_run && !w_full && !stall_i && !branch_flag_i;
  assign w_valid = !w_empty && (r_state != ST_ERR);
  assign w_pop   = w_valid && bus.id_ready_i;
  assign w_entry = {r_pc, bus.rom_inst_i};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fetch),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (w_branch),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control FSM: one settling cycle in IDLE, then RUN until a bad redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN:  r_state <= w_misalign ? ST_ERR : ST_RUN;
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // PC: redirect load has priority over sequential advance; wraps mod 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= branch_target_i;
    end else if (w_fetch) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign bus.rom_ce_o   = w_fetch;
  assign bus.rom_addr_o = r_pc[ROM_AW+1:2];
  assign bus.id_valid_o = w_valid;
  assign bus.id_pc_o    = w_head.pc;
  assign bus.id_inst_o  = w_head.inst;

  assign fetch_err_o = (r_state == ST_ERR);
  assign dbg_state_o = r_state;
  assign dbg_count_o = w_count;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a ROM model returns an address-derived word,
// the stimulus pushes every {pc, inst} decode should receive into exp_q, and
// a monitor compares each decode handshake against the queue head.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = 32'h0;
  logic        fetch_err;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_flag_i   (branch),
    .branch_target_i (target),
    .fetch_err_o     (fetch_err),
    .dbg_state_o     (dbg_state),
    .dbg_count_o     (dbg_count),
    .bus             (bus.master)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return {16'hC0DE, 10'h0, a};
  endfunction

  assign bus.rom_inst_i = bus.rom_ce_o ? rom_word(bus.rom_addr_o) : 32'h0;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic exp_push(input logic [31:0] pc);
    logic [5:0] a;
    a = pc[7:2];
    exp_q.push_back({pc, rom_word(a)});
  endtask

  task automatic do_reset(input logic rdy);
    rst_n  = 1'b0;
    stall  = 1'b0;
    branch = 1'b0;
    target = 32'h0;
    bus.id_ready_i = rdy;
    repeat (2) step();
    exp_q.delete();
  endtask

  // Leaves the bench in the IDLE cycle right after release.
  task automatic release_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic fetch_chk(input string name, input logic ce, input logic [5:0] addr);
    check({name, "_ce"}, {31'h0, bus.rom_ce_o}, {31'h0, ce});
    check({name, "_addr"}, {26'h0, bus.rom_addr_o}, {26'h0, addr});
  endtask

  // Let the buffer empty; every expected entry must have been delivered.
  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.id_valid_o) break;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid"}, {31'h0, bus.id_valid_o}, 32'd0);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  // A handshake in a cycle where execute redirects is cancelled, not delivered.
  always @(negedge clk) begin
    if (rst_n && bus.id_valid_o && bus.id_ready_i && !branch) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL deliver_unexpected: got pc %h inst %h, expected none", bus.id_pc_o, bus.id_inst_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("deliver_pc", bus.id_pc_o, mon_e[63:32]);
        check("deliver_inst", bus.id_inst_o, mon_e[31:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.id_ready_i = 1'b1;

    // Reset values and sequential fetch with decode always ready.
    do_reset(1'b1);
    at_neg();
    check("rst_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    check("rst_valid", {31'h0, bus.id_valid_o}, 32'd0);
    check("rst_err", {31'h0, fetch_err}, 32'd0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("rst_count", {30'h0, dbg_count}, 32'd0);
    for (int k = 0; k < 4; k++) exp_push(32'(k * 4));
    release_reset();
    at_neg();
    check("seq_idle_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      at_neg();
      fetch_chk("seq", 1'b1, 6'(k));
      if (k == 0) check("seq_lat_valid", {31'h0, bus.id_valid_o}, 32'd0);
      else        check("seq_lat_pc", bus.id_pc_o, 32'((k - 1) * 4));
    end
    step();
    stall = 1'b1;
    drain("seq");

    // Back-pressure: buffer fills, head holds, then drains in order.
    do_reset(1'b0);
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    release_reset();
    step(); step(); step();
    at_neg();
    fetch_chk("bp_full", 1'b0, 6'd2);
    check("bp_count", {30'h0, dbg_count}, 32'd2);
    check("bp_head", bus.id_pc_o, 32'h0);
    step();
    at_neg();
    check("bp_hold_pc", bus.id_pc_o, 32'h0);
    check("bp_hold_inst", bus.id_inst_o, rom_word(6'd0));
    step();
    bus.id_ready_i = 1'b1;
    at_neg();
    check("bp_nopass_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    at_neg();
    fetch_chk("bp_resume", 1'b1, 6'd2);
    step();
    stall = 1'b1;
    drain("bp");

    // Redirect to 0x40 with a full buffer, then reset mid-operation.
    do_reset(1'b0);
    exp_push(32'h40);
    release_reset();
    step(); step(); step();
    bus.id_ready_i = 1'b1;
    branch = 1'b1;
    target = 32'h40;
    at_neg();
    check("br_pre_count", {30'h0, dbg_count}, 32'd2);
    check("br_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    branch = 1'b0;
    at_neg();
    check("br_flush_count", {30'h0, dbg_count}, 32'd0);
    check("br_flush_valid", {31'h0, bus.id_valid_o}, 32'd0);
    fetch_chk("br_fetch", 1'b1, 6'd16);
    step();
    at_neg();
    fetch_chk("br_fetch2", 1'b1, 6'd17);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, bus.id_valid_o}, 32'd0);
    check("mid_rst_count", {30'h0, dbg_count}, 32'd0);
    check("mid_rst_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    check("mid_rst_q", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_push(32'h0);
    release_reset();
    at_neg();
    check("mid_rel_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    at_neg();
    fetch_chk("mid_rel_fetch", 1'b1, 6'd0);
    step();
    stall = 1'b1;
    drain("br");

    // Branch takes priority over stall.
    do_reset(1'b1);
    exp_push(32'h80);
    release_reset();
    step();
    step();
    stall = 1'b1;
    branch = 1'b1;
    target = 32'h80;
    at_neg();
    check("stbr_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    branch = 1'b0;
    at_neg();
    fetch_chk("stbr_hold", 1'b0, 6'd32);
    check("stbr_count", {30'h0, dbg_count}, 32'd0);
    step();
    stall = 1'b0;
    at_neg();
    fetch_chk("stbr_fetch", 1'b1, 6'd32);
    step();
    stall = 1'b1;
    drain("stbr");

    // Misaligned redirect: sticky error until reset.
    do_reset(1'b1);
    release_reset();
    step();
    step();
    branch = 1'b1;
    target = 32'h42;
    at_neg();
    check("err_br_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    branch = 1'b0;
    at_neg();
    check("err_flag", {31'h0, fetch_err}, 32'd1);
    check("err_state", {30'h0, dbg_state}, {30'h0, ST_ERR});
    check("err_valid", {31'h0, bus.id_valid_o}, 32'd0);
    check("err_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    branch = 1'b1;
    target = 32'h40;
    step();
    at_neg();
    check("err_ign_flag", {31'h0, fetch_err}, 32'd1);
    check("err_ign_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    branch = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err_rst_flag", {31'h0, fetch_err}, 32'd0);
    check("err_rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    exp_q.delete();
    exp_push(32'h0);
    release_reset();
    at_neg();
    check("err_rel_ce", {31'h0, bus.rom_ce_o}, 32'd0);
    step();
    at_neg();
    fetch_chk("err_restart", 1'b1, 6'd0);
    step();
    stall = 1'b1;
    drain("err");

    // ROM address aliasing at 0x100 and PC wrap at 2^32.
    do_reset(1'b1);
    exp_push(32'hF8); exp_push(32'hFC); exp_push(32'h100);
    exp_push(32'hFFFF_FFFC); exp_push(32'h0);
    release_reset();
    step();
    step();
    branch = 1'b1;
    target = 32'hF8;
    step();
    branch = 1'b0;
    at_neg();
    fetch_chk("wrap_62", 1'b1, 6'd62);
    step();
    at_neg();
    fetch_chk("wrap_63", 1'b1, 6'd63);
    step();
    at_neg();
    fetch_chk("wrap_0", 1'b1, 6'd0);
    step();
    stall = 1'b1;
    step();
    branch = 1'b1;
    target = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    stall = 1'b0;
    at_neg();
    fetch_chk("wrap32_63", 1'b1, 6'd63);
    step();
    at_neg();
    fetch_chk("wrap32_0", 1'b1, 6'd0);
    step();
    stall = 1'b1;
    drain("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
